// File: rtl/multi_port_fifo.sv
// Superscalar FIFO: up to N_ENQ writes and N_DEQ reads per clock through
// per-lane ready/valid handshakes with prefix (leading-lane) semantics.
// All outputs derive from registered state only; flush empties in one cycle.
module multi_port_fifo #(
   parameter int N_ENTRIES   = 8,
   parameter int ENTRY_WIDTH = 32,
   parameter int N_ENQ       = 2,
   parameter int N_DEQ       = 2,
   parameter int AF_THRESH   = N_ENTRIES - N_ENQ
) (
   input  logic                                clk,
   input  logic                                rst_aL,
   input  logic                                flush,
   output logic [N_ENQ-1:0]                    enq_ready,
   input  logic [N_ENQ-1:0]                    enq_valid,
   input  logic [N_ENQ*ENTRY_WIDTH-1:0]        enq_data,
   input  logic [N_DEQ-1:0]                    deq_ready,
   output logic [N_DEQ-1:0]                    deq_valid,
   output logic [N_DEQ*ENTRY_WIDTH-1:0]        deq_data,
   output logic [$clog2(N_ENTRIES):0]          count,
   output logic                                almost_full
);

   localparam int PTR_WIDTH = $clog2(N_ENTRIES);
   localparam int CTR_WIDTH = PTR_WIDTH + 1;
   localparam logic [CTR_WIDTH-1:0] DEPTH = CTR_WIDTH'(N_ENTRIES);

   // Counters carry one extra wrap bit so full and empty are distinguishable.
   logic [CTR_WIDTH-1:0]   enq_ctr;
   logic [CTR_WIDTH-1:0]   deq_ctr;
   logic [PTR_WIDTH-1:0]   enq_ptr;
   logic [PTR_WIDTH-1:0]   deq_ptr;
   logic [CTR_WIDTH-1:0]   free_slots;
   logic [CTR_WIDTH-1:0]   n_enq;
   logic [CTR_WIDTH-1:0]   n_deq;
   logic                   enq_stop;
   logic                   deq_stop;
   logic [ENTRY_WIDTH-1:0] mem [N_ENTRIES];

   assign enq_ptr    = enq_ctr[PTR_WIDTH-1:0];
   assign deq_ptr    = deq_ctr[PTR_WIDTH-1:0];
   assign count      = enq_ctr - deq_ctr;
   assign free_slots = DEPTH - count;
   assign almost_full = ({{(32-CTR_WIDTH){1'b0}}, count} >= 32'(AF_THRESH));

   // Per-lane status from registered occupancy only (no same-cycle bypass).
   always_comb begin
      enq_ready = '0;
      deq_valid = '0;
      for (int i = 0; i < N_ENQ; i++)
         enq_ready[i] = (free_slots > CTR_WIDTH'(i));
      for (int j = 0; j < N_DEQ; j++)
         deq_valid[j] = (count > CTR_WIDTH'(j));
   end

   // Read lanes present consecutive entries starting at the head, wrapping.
   always_comb begin
      deq_data = '0;
      for (int j = 0; j < N_DEQ; j++)
         deq_data[j*ENTRY_WIDTH +: ENTRY_WIDTH] = mem[deq_ptr + PTR_WIDTH'(j)];
   end

   // Accepted enqueue count: leading lanes with a completed handshake.
   always_comb begin
      n_enq    = '0;
      enq_stop = 1'b0;
      for (int i = 0; i < N_ENQ; i++) begin
         if (!enq_stop && enq_valid[i] && enq_ready[i])
            n_enq = n_enq + CTR_WIDTH'(1);
         else
            enq_stop = 1'b1;
      end
   end

   // Accepted dequeue count: leading lanes with a completed handshake.
   always_comb begin
      n_deq    = '0;
      deq_stop = 1'b0;
      for (int j = 0; j < N_DEQ; j++) begin
         if (!deq_stop && deq_valid[j] && deq_ready[j])
            n_deq = n_deq + CTR_WIDTH'(1);
         else
            deq_stop = 1'b1;
      end
   end

   // Counter update; flush overrides any handshakes in the same cycle.
   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         enq_ctr <= '0;
         deq_ctr <= '0;
      end else if (flush) begin
         enq_ctr <= '0;
         deq_ctr <= '0;
      end else begin
         enq_ctr <= enq_ctr + n_enq;
         deq_ctr <= deq_ctr + n_deq;
      end
   end

   // Storage write for accepted lanes; flush leaves contents untouched.
   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         for (int k = 0; k < N_ENTRIES; k++)
            mem[k] <= '0;
      end else if (!flush) begin
         for (int i = 0; i < N_ENQ; i++)
            if (CTR_WIDTH'(i) < n_enq)
               mem[enq_ptr + PTR_WIDTH'(i)] <= enq_data[i*ENTRY_WIDTH +: ENTRY_WIDTH];
      end
   end

endmodule

// File: tb/tb_multi_port_fifo.sv
// Bench for multi_port_fifo (8 entries, 2+2 lanes, AF_THRESH 6): vector
// table, hand sequences for reset/wrap/streaming, then a random run against
// a queue-based model.
module tb_multi_port_fifo;

   logic        clk;
   logic        rst_aL;
   logic        flush;
   logic [1:0]  enq_ready;
   logic [1:0]  enq_valid;
   logic [63:0] enq_data;
   logic [1:0]  deq_ready;
   logic [1:0]  deq_valid;
   logic [63:0] deq_data;
   logic [3:0]  count;
   logic        almost_full;

   int total = 0;
   int bad   = 0;

   multi_port_fifo #(
      .N_ENTRIES(8), .ENTRY_WIDTH(32), .N_ENQ(2), .N_DEQ(2), .AF_THRESH(6)
   ) dut (
      .clk(clk), .rst_aL(rst_aL), .flush(flush),
      .enq_ready(enq_ready), .enq_valid(enq_valid), .enq_data(enq_data),
      .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_data(deq_data),
      .count(count), .almost_full(almost_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  ev;
      logic [31:0] e1;
      logic [31:0] e0;
      logic [1:0]  dr;
      logic        fl;
      int          cnt;
      logic [1:0]  dv;
      logic [1:0]  er;
      logic        af;
      logic [31:0] d0;
      logic [31:0] d1;
   } vec_t;

   vec_t tbl[14];
   logic [31:0] q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic drive(input logic [1:0] ev, input logic [31:0] e1, input logic [31:0] e0,
                        input logic [1:0] dr, input logic fl);
      enq_valid = ev;
      enq_data  = {e1, e0};
      deq_ready = dr;
      flush     = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush();
      drive(2'b00, 0, 0, 2'b00, 1'b1);
      tick();
      drive(2'b00, 0, 0, 2'b00, 1'b0);
   endtask

   // Compare every output against the queue model.
   task automatic check_model();
      int sz;
      logic [1:0] er, dv;
      sz = q.size();
      for (int i = 0; i < 2; i++) begin
         er[i] = ((8 - sz) > i);
         dv[i] = (sz > i);
      end
      chk("m_count", 64'(count), 64'(sz));
      chk("m_enq_ready", 64'(enq_ready), 64'(er));
      chk("m_deq_valid", 64'(deq_valid), 64'(dv));
      chk("m_almost_full", 64'(almost_full), 64'(sz >= 6));
      if (sz > 0) chk("m_deq_data0", 64'(deq_data[31:0]), 64'(q[0]));
      if (sz > 1) chk("m_deq_data1", 64'(deq_data[63:32]), 64'(q[1]));
   endtask

   // Apply one random cycle to DUT and model.
   task automatic rand_cycle();
      logic [1:0]  ev, dr;
      logic        fl;
      logic [31:0] e0, e1;
      int sz, ne, nd;
      logic stop;
      ev = 2'($urandom_range(0, 3));
      dr = 2'($urandom_range(0, 3));
      fl = ($urandom_range(0, 24) == 0);
      e0 = $urandom;
      e1 = $urandom;
      sz = q.size();
      ne = 0; stop = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (!stop && ev[i] && ((8 - sz) > i)) ne++;
         else stop = 1'b1;
      end
      nd = 0; stop = 1'b0;
      for (int j = 0; j < 2; j++) begin
         if (!stop && dr[j] && (sz > j)) nd++;
         else stop = 1'b1;
      end
      drive(ev, e1, e0, dr, fl);
      tick();
      if (fl) begin
         q.delete();
      end else begin
         for (int k = 0; k < nd; k++) void'(q.pop_front());
         if (ne > 0) q.push_back(e0);
         if (ne > 1) q.push_back(e1);
      end
      check_model();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] wr_seq, rd_seq;

      tbl[0]  = '{2'b11, 32'hB,  32'hA,  2'b00, 1'b0, 2, 2'b11, 2'b11, 1'b0, 32'hA, 32'hB};
      tbl[1]  = '{2'b00, 32'h0,  32'h0,  2'b11, 1'b0, 0, 2'b00, 2'b11, 1'b0, 32'h0, 32'h0};
      tbl[2]  = '{2'b11, 32'h2,  32'h1,  2'b00, 1'b0, 2, 2'b11, 2'b11, 1'b0, 32'h1, 32'h2};
      tbl[3]  = '{2'b11, 32'h4,  32'h3,  2'b00, 1'b0, 4, 2'b11, 2'b11, 1'b0, 32'h1, 32'h2};
      tbl[4]  = '{2'b11, 32'h6,  32'h5,  2'b00, 1'b0, 6, 2'b11, 2'b11, 1'b1, 32'h1, 32'h2};
      tbl[5]  = '{2'b11, 32'h8,  32'h7,  2'b00, 1'b0, 8, 2'b11, 2'b00, 1'b1, 32'h1, 32'h2};
      tbl[6]  = '{2'b11, 32'hA,  32'h9,  2'b00, 1'b0, 8, 2'b11, 2'b00, 1'b1, 32'h1, 32'h2};
      tbl[7]  = '{2'b00, 32'h0,  32'h0,  2'b01, 1'b0, 7, 2'b11, 2'b01, 1'b1, 32'h2, 32'h3};
      tbl[8]  = '{2'b11, 32'h22, 32'h11, 2'b00, 1'b0, 8, 2'b11, 2'b00, 1'b1, 32'h2, 32'h3};
      tbl[9]  = '{2'b00, 32'h0,  32'h0,  2'b10, 1'b0, 8, 2'b11, 2'b00, 1'b1, 32'h2, 32'h3};
      tbl[10] = '{2'b00, 32'h0,  32'h0,  2'b11, 1'b0, 6, 2'b11, 2'b11, 1'b1, 32'h4, 32'h5};
      tbl[11] = '{2'b11, 32'hEE, 32'hDD, 2'b11, 1'b1, 0, 2'b00, 2'b11, 1'b0, 32'h0, 32'h0};
      tbl[12] = '{2'b10, 32'h44, 32'h0,  2'b00, 1'b0, 0, 2'b00, 2'b11, 1'b0, 32'h0, 32'h0};
      tbl[13] = '{2'b01, 32'h0,  32'h33, 2'b00, 1'b0, 1, 2'b01, 2'b11, 1'b0, 32'h33, 32'h0};

      // Power-on reset and reset-state outputs.
      drive(2'b00, 0, 0, 2'b00, 1'b0);
      rst_aL = 1'b1;
      #1 rst_aL = 1'b0;
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_deq_valid", 64'(deq_valid), 64'b00);
      chk("rst_enq_ready", 64'(enq_ready), 64'b11);
      chk("rst_almost_full", 64'(almost_full), 64'd0);
      chk("rst_deq_data", deq_data, 64'd0);
      #10 rst_aL = 1'b1;

      // Vector table, one cycle per record.
      for (int v = 0; v < 14; v++) begin
         drive(tbl[v].ev, tbl[v].e1, tbl[v].e0, tbl[v].dr, tbl[v].fl);
         tick();
         chk($sformatf("vec%0d_count", v), 64'(count), 64'(tbl[v].cnt));
         chk($sformatf("vec%0d_deq_valid", v), 64'(deq_valid), 64'(tbl[v].dv));
         chk($sformatf("vec%0d_enq_ready", v), 64'(enq_ready), 64'(tbl[v].er));
         chk($sformatf("vec%0d_almost_full", v), 64'(almost_full), 64'(tbl[v].af));
         if (tbl[v].dv[0]) chk($sformatf("vec%0d_data0", v), 64'(deq_data[31:0]), 64'(tbl[v].d0));
         if (tbl[v].dv[1]) chk($sformatf("vec%0d_data1", v), 64'(deq_data[63:32]), 64'(tbl[v].d1));
      end
      drive(2'b00, 0, 0, 2'b00, 1'b0);

      // Wrap: move both pointers to 7, then a two-lane write spans 7 -> 0.
      do_flush();
      for (int k = 0; k < 3; k++) begin drive(2'b11, 32'h90, 32'h90, 2'b00, 1'b0); tick(); end
      drive(2'b01, 0, 32'h90, 2'b00, 1'b0); tick();
      for (int k = 0; k < 3; k++) begin drive(2'b00, 0, 0, 2'b11, 1'b0); tick(); end
      drive(2'b00, 0, 0, 2'b01, 1'b0); tick();
      chk("wrap_empty", 64'(count), 64'd0);
      drive(2'b11, 32'h2, 32'h1, 2'b00, 1'b0); tick();
      chk("wrap_count2", 64'(count), 64'd2);
      chk("wrap_lane0", 64'(deq_data[31:0]), 64'h1);
      chk("wrap_lane1", 64'(deq_data[63:32]), 64'h2);
      drive(2'b00, 0, 0, 2'b01, 1'b0); tick();
      chk("wrap_pop1", 64'(deq_data[31:0]), 64'h2);
      chk("wrap_count1", 64'(count), 64'd1);
      drive(2'b00, 0, 0, 2'b01, 1'b0); tick();
      chk("wrap_count0", 64'(count), 64'd0);
      drive(2'b10, 32'h55, 32'h44, 2'b00, 1'b0); tick();
      chk("gap_count", 64'(count), 64'd0);
      chk("gap_deq_valid", 64'(deq_valid), 64'b00);
      drive(2'b01, 0, 32'h77, 2'b00, 1'b0); tick();
      chk("gap_after_write", 64'(deq_data[31:0]), 64'h77);

      // Streaming at count 4: two in, two out for 20 cycles.
      do_flush();
      wr_seq = 32'hC000_0000;
      rd_seq = 32'hC000_0000;
      for (int k = 0; k < 2; k++) begin
         drive(2'b11, wr_seq + 1, wr_seq, 2'b00, 1'b0); tick();
         wr_seq += 2;
      end
      for (int k = 0; k < 20; k++) begin
         chk("stream_count", 64'(count), 64'd4);
         chk("stream_lane0", 64'(deq_data[31:0]), 64'(rd_seq));
         chk("stream_lane1", 64'(deq_data[63:32]), 64'(rd_seq + 1));
         drive(2'b11, wr_seq + 1, wr_seq, 2'b11, 1'b0); tick();
         wr_seq += 2;
         rd_seq += 2;
      end
      chk("stream_end_count", 64'(count), 64'd4);

      // Asynchronous reset mid-cycle with five entries held.
      do_flush();
      drive(2'b11, 32'h12, 32'h11, 2'b00, 1'b0); tick();
      drive(2'b11, 32'h14, 32'h13, 2'b00, 1'b0); tick();
      drive(2'b01, 32'h0, 32'h15, 2'b00, 1'b0); tick();
      drive(2'b00, 0, 0, 2'b00, 1'b0);
      chk("pre_rst_count", 64'(count), 64'd5);
      #3 rst_aL = 1'b0;
      #1;
      chk("async_rst_count", 64'(count), 64'd0);
      chk("async_rst_deq_valid", 64'(deq_valid), 64'b00);
      chk("async_rst_enq_ready", 64'(enq_ready), 64'b11);
      chk("async_rst_deq_data", deq_data, 64'd0);
      #1 rst_aL = 1'b1;
      tick();
      chk("post_rst_count", 64'(count), 64'd0);

      // Random traffic against the queue model.
      q.delete();
      do_flush();
      check_model();
      for (int k = 0; k < 400; k++) rand_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
